da_z0_sequencer: RTL and testbench

//  Bit-serial distributed-arithmetic (DA) sequencer for the z0 row of the 8-point DCT stage.

---
 rtl/da_z0_sequencer.sv | 159 +++++++++++++++
 tb/tb_da_z0_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/da_z0_sequencer.sv
// -----------------------------------------------------------------------------
// da_z0_sequencer
//   Bit-serial distributed-arithmetic sequencer for the z0 row of the 8-point
//   DCT stage. One 4-sample butterfly vector is accepted, its bits are walked
//   MSB-first, each bit slice addresses the external z0 coefficient ROM, and
//   the ROM terms are shift-accumulated into a raw signed DA sum.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          synchronous active-high reset
//   in_valid   in   1          x_in valid
//   in_ready   out  1          block can accept x_in (IDLE)
//   x_in       in   4*DATA_W   {x3,x2,x1,x0}, x0 in the low DATA_W bits
//   rom_addr   out  3          ROM address (0 outside CALC)
//   rom_cs     out  1          ROM chip select (CALC only)
//   rom_data   in   ROM_W      signed Q2.14 ROM word, same-cycle
//   out_valid  out  1          z_out valid (DONE)
//   out_ready  in   1          downstream accepts z_out
//   z_out      out  ACC_W      signed raw DA sum
//   busy       out  1          high in CALC or DONE
// -----------------------------------------------------------------------------
module da_z0_sequencer #(
  parameter int DATA_W = 16,
  parameter int ROM_W  = 16,
  parameter int ACC_W  = DATA_W + ROM_W + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DATA_W-1:0] x_in,
  output logic [2:0]          rom_addr,
  output logic                rom_cs,
  input  logic [ROM_W-1:0]    rom_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    z_out,
  output logic                busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_rom_cs;
  logic [DATA_W-1:0]   r_sr0, r_sr1, r_sr2, r_sr3;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    r_z;

  logic                w_b0, w_b1, w_b2, w_b3;
  logic [2:0]          w_sel;
  logic [2:0]          w_addr;
  logic [ACC_W-1:0]    w_rom_sext;
  logic [ACC_W-1:0]    w_t;
  logic [ACC_W-1:0]    w_acc_next;
  logic                w_first_bit;
  logic                w_last_bit;

  // Current bit slice: MSB of each shift register.
  assign w_b0 = r_sr0[DATA_W-1];
  assign w_b1 = r_sr1[DATA_W-1];
  assign w_b2 = r_sr2[DATA_W-1];
  assign w_b3 = r_sr3[DATA_W-1];

  // Offset-binary folding: when b0 is set the complemented address is used
  // and the term is negated, halving the ROM to 8 entries.
  assign w_sel  = {w_b1, w_b2, w_b3};
  assign w_addr = w_b0 ? ~w_sel : w_sel;

  // Sign-extend before negating so the most negative ROM word negates exactly.
  assign w_rom_sext = {{(ACC_W-ROM_W){rom_data[ROM_W-1]}}, rom_data};
  assign w_t        = w_b0 ? (-w_rom_sext) : w_rom_sext;

  assign w_first_bit = (r_bit_cnt == CNT_W'(DATA_W-1));
  assign w_last_bit  = (r_bit_cnt == '0);

  // Sign-bit slice carries negative weight.
  assign w_acc_next = w_first_bit ? (-w_t) : ((r_acc << 1) + w_t);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rom_cs    <= 1'b0;
      r_sr0       <= '0;
      r_sr1       <= '0;
      r_sr2       <= '0;
      r_sr3       <= '0;
      r_bit_cnt   <= '0;
      r_acc       <= '0;
      r_z         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sr0      <= x_in[0*DATA_W +: DATA_W];
            r_sr1      <= x_in[1*DATA_W +: DATA_W];
            r_sr2      <= x_in[2*DATA_W +: DATA_W];
            r_sr3      <= x_in[3*DATA_W +: DATA_W];
            r_bit_cnt  <= CNT_W'(DATA_W-1);
            r_acc      <= '0;
            r_state    <= S_CALC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_rom_cs   <= 1'b1;
          end
        end
        S_CALC: begin
          r_acc     <= w_acc_next;
          r_sr0     <= r_sr0 << 1;
          r_sr1     <= r_sr1 << 1;
          r_sr2     <= r_sr2 << 1;
          r_sr3     <= r_sr3 << 1;
          r_bit_cnt <= r_bit_cnt - 1'b1;
          if (w_last_bit) begin
            r_z         <= w_acc_next;
            r_state     <= S_DONE;
            r_rom_cs    <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_rom_cs    <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign rom_cs    = r_rom_cs;
  assign rom_addr  = r_rom_cs ? w_addr : 3'b000;
  assign z_out     = r_z;

endmodule

// File: tb/tb_da_z0_sequencer.sv
// -----------------------------------------------------------------------------
// tb_da_z0_sequencer
//   Directed bench for da_z0_sequencer with a behavioural z0 ROM. Inputs are
//   driven on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_da_z0_sequencer;

  localparam int DATA_W = 16;
  localparam int ROM_W  = 16;
  localparam int ACC_W  = DATA_W + ROM_W + 1;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [4*DATA_W-1:0] x_in;
  logic [2:0]          rom_addr;
  logic                rom_cs;
  logic [ROM_W-1:0]    rom_data;
  logic                out_valid;
  logic                out_ready;
  logic [ACC_W-1:0]    z_out;
  logic                busy;

  int total;
  int bad;
  int cyc;

  da_z0_sequencer #(
    .DATA_W(DATA_W),
    .ROM_W (ROM_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_data (rom_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .z_out    (z_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // z0 coefficient ROM model
  always_comb begin
    case (rom_addr)
      3'b000:                rom_data = 16'hA57D;
      3'b001, 3'b010, 3'b100: rom_data = 16'hD2BE;
      3'b111:                rom_data = 16'h2D41;
      default:               rom_data = 16'h0000;
    endcase
  end

  function automatic logic [4*DATA_W-1:0] vec4(input logic [15:0] a0, input logic [15:0] a1,
                                               input logic [15:0] a2, input logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [ACC_W-1:0] sx(input int v);
    return ACC_W'(signed'(v));
  endfunction

  // Presents a vector, waits for acceptance, then counts edges until out_valid.
  // Leaves the bench at the falling edge where out_valid was first seen.
  task automatic run_vec(input logic [4*DATA_W-1:0] v, output logic [ACC_W-1:0] z,
                         output int lat, output logic ok, output logic [2:0] addr0,
                         output logic cs0);
    int w;
    ok = 1'b0; lat = 0; z = '0; addr0 = '0; cs0 = 1'b0;
    x_in = v;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk); w++;
    end
    if (!in_ready) return;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    addr0 = rom_addr;
    cs0   = rom_cs;
    while (!out_valid && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
    if (out_valid) begin
      ok = 1'b1;
      z  = z_out;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, rom_cs, busy} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_flags got in_ready/out_valid/rom_cs/busy=%b want 1000",
               {in_ready, out_valid, rom_cs, busy});
    end
    total++;
    if (z_out !== '0 || rom_addr !== 3'b000) begin
      bad++;
      $display("FAIL reset_data got z_out=%0h rom_addr=%b want 0/000", z_out, rom_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [4*DATA_W-1:0] v [6];
    int                  ez [6];
    logic [2:0]          ea [6];
    logic [ACC_W-1:0]    z;
    int                  lat;
    logic                ok, cs0;
    logic [2:0]          a0;
    v[0] = vec4(16'h0000, 16'h0000, 16'h0000, 16'h0000); ez[0] =  23171; ea[0] = 3'b000;
    v[1] = vec4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF); ez[1] = -23171; ea[1] = 3'b000;
    v[2] = vec4(16'h0001, 16'h0001, 16'h0001, 16'h0001); ez[2] =  69513; ea[2] = 3'b000;
    v[3] = vec4(16'h0000, 16'hFFFF, 16'h0000, 16'h0000); ez[3] =  11586; ea[3] = 3'b100;
    v[4] = vec4(16'hFFFF, 16'h0000, 16'h0000, 16'h0000); ez[4] =  11585; ea[4] = 3'b111;
    v[5] = vec4(16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000); ez[5] =      0; ea[5] = 3'b110;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_vec(v[i], z, lat, ok, a0, cs0);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL vec%0d_timeout got no out_valid want out_valid", i);
      end
      total++;
      if (z !== sx(ez[i])) begin
        bad++;
        $display("FAIL vec%0d_z got %0d want %0d", i, $signed(z), ez[i]);
      end
      total++;
      if (lat !== DATA_W) begin
        bad++;
        $display("FAIL vec%0d_latency got %0d want %0d", i, lat, DATA_W);
      end
      total++;
      if (a0 !== ea[i] || cs0 !== 1'b1) begin
        bad++;
        $display("FAIL vec%0d_rom got addr=%b cs=%b want addr=%b cs=1", i, a0, cs0, ea[i]);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_release got out_valid=%b in_ready=%b busy=%b want 0 1 0",
                 i, out_valid, in_ready, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [ACC_W-1:0] z;
    int               lat;
    logic             ok, cs0;
    logic [2:0]       a0;
    int               errs;
    out_ready = 1'b0;
    run_vec(vec4(16'h0000, 16'h0000, 16'h0000, 16'h0000), z, lat, ok, a0, cs0);
    total++;
    if (!ok || z !== sx(23171)) begin
      bad++;
      $display("FAIL bp_first got ok=%b z=%0d want 1 23171", ok, $signed(z));
    end
    errs = 0;
    in_valid = 1'b1;
    x_in = vec4(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || z_out !== sx(23171) || in_ready !== 1'b0 || busy !== 1'b1)
        errs++;
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL bp_hold got %0d bad stall cycles want 0", errs);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset_midcalc();
    logic [ACC_W-1:0] z;
    int               lat, w;
    logic             ok, cs0, seen;
    logic [2:0]       a0;
    out_ready = 1'b1;
    x_in = vec4(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk); w++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    total++;
    if (rom_cs !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_precheck got rom_cs=%b busy=%b want 1 1", rom_cs, busy);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || rom_cs !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_flags got in_ready=%b rom_cs=%b out_valid=%b busy=%b want 1 0 0 0",
               in_ready, rom_cs, out_valid, busy);
    end
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_no_valid got out_valid asserted want never");
    end
    run_vec(vec4(16'h0001, 16'h0001, 16'h0001, 16'h0001), z, lat, ok, a0, cs0);
    total++;
    if (!ok || z !== sx(69513)) begin
      bad++;
      $display("FAIL rst_mid_recover got ok=%b z=%0d want 1 69513", ok, $signed(z));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [4*DATA_W-1:0] v [3];
    int                  ez [3];
    int                  tv [3];
    int                  n_acc, n_res, guard;
    v[0] = vec4(16'h0000, 16'h0000, 16'h0000, 16'h0000); ez[0] =  23171;
    v[1] = vec4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF); ez[1] = -23171;
    v[2] = vec4(16'h0001, 16'h0001, 16'h0001, 16'h0001); ez[2] =  69513;
    out_ready = 1'b1;
    n_acc = 0; n_res = 0; guard = 0;
    while (n_res < 3 && guard < 200) begin
      if (out_valid) begin
        total++;
        if (z_out !== sx(ez[n_res])) begin
          bad++;
          $display("FAIL b2b%0d_z got %0d want %0d", n_res, $signed(z_out), ez[n_res]);
        end
        tv[n_res] = cyc;
        n_res++;
      end
      if (in_ready) begin
        if (n_acc < 3) begin
          x_in = v[n_acc];
          in_valid = 1'b1;
          n_acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    total++;
    if (n_res !== 3) begin
      bad++;
      $display("FAIL b2b_count got %0d results want 3", n_res);
    end else begin
      total++;
      if (tv[1] - tv[0] !== DATA_W + 2 || tv[2] - tv[1] !== DATA_W + 2) begin
        bad++;
        $display("FAIL b2b_period got %0d,%0d want %0d", tv[1] - tv[0], tv[2] - tv[1],
                 DATA_W + 2);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x_in = '0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_midcalc();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
